// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode, ALU and branch encodings plus default datapath widths.
package cpu_defs;

  localparam int unsigned DEF_PC_W    = 8;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned OP_W        = 4;

  // Instruction opcodes, carried in instr[15:12]
  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_LDI = 4'b1000,
    OP_LD  = 4'b1001,
    OP_ST  = 4'b1010,
    OP_JMP = 4'b1011,
    OP_BZ  = 4'b1100
  } opcode_e;

  // ALU operation selects used by execute
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  // Branch kinds resolved in execute
  typedef enum logic [1:0] {
    BRANCH_NONE = 2'd0,
    BRANCH_JMP  = 2'd1,
    BRANCH_BZ   = 2'd2
  } branch_e;

  // All-zero word decodes as NOP
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Extract the opcode field of an instruction
  function automatic opcode_e opcode_of(input logic [DEF_INSTR_W-1:0] instr);
    return opcode_e'(instr[15:12]);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with single-cycle flush. DEPTH must be a power of two, >= 2,
// so the pointers wrap naturally. The head word comes straight from storage flops.
module fetch_queue #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_wr;
  logic             do_rd;

  // Reads only from a non-empty queue; a write into a full queue needs a same-cycle read
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[head];

  // Pointer and occupancy bookkeeping; flush behaves like a reset of the control state
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wr) tail <= tail + PTR_W'(1);
      if (do_rd) head <= head + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (do_wr && !flush && !rst) mem[tail] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, queues {pc, instr} pairs from the
// combinational instruction memory and hands them to decode over valid/ready.
// Branch redirects flush everything not yet accepted by decode.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned    PC_W     = DEF_PC_W,
  parameter int unsigned    INSTR_W  = DEF_INSTR_W,
  parameter int unsigned    DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic [PC_W-1:0]        imem_pc,
  input  logic [INSTR_W-1:0]     imem_instr,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_W-1:0]     id_instr,
  output logic [PC_W-1:0]        id_pc,
  input  logic                   br_taken,
  input  logic [PC_W-1:0]        br_target,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned ENT_W = PC_W + INSTR_W;

  logic [PC_W-1:0]  pc;
  logic             enq;
  logic             deq;
  logic             q_full;
  logic             q_empty;
  logic [ENT_W-1:0] head_data;

  // Handshake arbitration: a redirect suppresses the enqueue of its own cycle
  assign id_valid = ~q_empty;
  assign deq      = id_valid & id_ready;
  assign enq      = fetch_en & ~br_taken & (~q_full | deq);
  assign imem_pc  = pc;

  // Program counter: reset, then redirect, then sequential advance (wraps mod 2^PC_W)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= br_target;
    end else if (enq) begin
      pc <= pc + PC_W'(1);
    end
  end

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (br_taken),
    .wr_en   (enq),
    .wr_data ({pc, imem_instr}),
    .rd_en   (deq),
    .rd_data (head_data),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Decode sees a NOP at pc 0 whenever nothing valid is queued
  assign id_pc    = id_valid ? head_data[ENT_W-1 -: PC_W] : '0;
  assign id_instr = id_valid ? head_data[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that owns the program counter and drives the 8-bit pc into the combinational instruction memory.
- Captures the returned 16-bit instruction into a small FIFO and presents it to the decode stage over a valid/ready handshake.
- Accepts branch redirects (BZ resolution) from execute, which flush all fetched-but-unissued instructions.
- Sits between instruction_mem and the decode stage.

Parameters:
- PC_W, 8, program-counter / instruction-memory address width.
- INSTR_W, 16, instruction width; opcode is bits [15:12].
- DEPTH, 2, fetch-queue entries; must be a power of 2, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  enables fetching; low freezes pc and stops enqueues; dequeue continues.
- imem_pc  out  PC_W  address to instruction memory; equals the pc register.
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_pc in the same cycle.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  INSTR_W  head instruction; 0 (NOP) when id_valid=0.
- id_pc  out  PC_W  address of the head instruction; 0 when id_valid=0.
- br_taken  in  1  redirect request from execute; single-cycle pulse.
- br_target  in  PC_W  redirect address, sampled when br_taken=1.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy, for debug and verification.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc<=RESET_PC, queue emptied (q_count=0, head/tail pointers=0).
  - id_valid=0, id_instr=0, id_pc=0 from the next cycle.
  - rst overrides br_taken, fetch_en and handshakes; a reset mid-stream discards all queued entries.
- deq = id_valid & id_ready.
- enq = fetch_en & !br_taken & (q_count<DEPTH | deq). Enqueueing into a full queue is allowed only when a dequeue happens in the same cycle.
- On enq:
  - Write {imem_pc, imem_instr} at the tail and advance the tail.
  - pc<=pc+1, modulo 2^PC_W, so 8'hFF wraps to 8'h00 with no flag.
- On deq:
  - Advance the head.
  - Outputs show the next entry, or zeros if the queue becomes empty.
- q_count update: q_count <= q_count + enq - deq. Simultaneous enq and deq leaves the count unchanged.
- Redirect (br_taken=1, rst=0):
  - Queue flushed (q_count<=0, pointers reset), pc<=br_target, no enqueue that cycle.
  - A head accepted that same cycle (deq=1) still counts as consumed by decode; the flush discards only the remaining entries.
  - Redirect has priority over fetch_en=0, so pc is still loaded.
- Latency:
  - An instruction at pc is enqueued at edge N and visible on id_* in cycle N+1.
  - After a redirect at edge N, the first target instruction is enqueued at edge N+1 and visible in cycle N+2.
- Throughput: 1 instruction/cycle sustained when id_ready=1 continuously.
- Stall (id_ready=0):
  - The queue fills to DEPTH, then pc holds.
  - id_* must remain stable while id_valid=1 and id_ready=0.
- fetch_en=0: pc holds and the queue drains normally.
- The head is registered; id_instr and id_pc carry no combinational path from imem_instr. id_valid depends only on q_count.

Decomposition:
- Shared package cpu_defs: OP_* opcodes (OP_NOP=4'b0000 ... OP_BZ=4'b1100), ALU_* and BRANCH_* codes, PC_W/INSTR_W defaults, and the NOP encoding (16'h0000).
- One sub-module: fetch_queue, a generic synchronous FIFO with flush.
  - Ports: clk, rst, flush, wr_en, wr_data, rd_en, rd_data, count, full, empty. Width = PC_W+INSTR_W.
  - fetch_unit holds the pc logic, the enq/deq arbitration and the zero-masking of outputs.

Test Plan:
- Reset then free-run: rst high 2 cycles, ROM[0..3]=16'h1123,16'h2456,16'h9701,16'hC002, id_ready=1 → id_valid rises 1 cycle after rst low; id_pc 0,1,2,3 on consecutive cycles with matching id_instr.
- Backpressure: id_ready=0 for 5 cycles from pc=0 → q_count reaches 2, imem_pc holds at 2, id_pc=0 stable; on id_ready=1, pcs 0,1,2 delivered in order with no loss or duplication.
- Redirect while full: queue holds pc 4,5, br_taken=1, br_target=8'h40 → next cycle q_count=0, imem_pc=8'h40; next id_pc=8'h40 two cycles after the pulse; 4 and 5 are never accepted.
- Redirect with simultaneous dequeue: head pc=7 accepted in the same cycle as br_taken to 8'h10 → pc 7 counted once, the remaining entry is dropped, the next delivered pc is 8'h10.
- PC wrap and fetch_en: start at br_target=8'hFE with id_ready=1 → pcs FE,FF,00,01 delivered. Then fetch_en=0 for 3 cycles → imem_pc frozen, queue drains to empty, id_valid=0, id_instr=0.
- Mid-stream reset: rst=1 with q_count=2 and a concurrent br_taken → next cycle q_count=0, imem_pc=RESET_PC, id_valid=0; the branch is ignored.
